// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the front end and the decoder.
// Holds the instruction width, the NOP encoding, the 4-bit opcode values
// used by the controller decode, and the fetch-unit state encoding.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_IMM = 4'b1001;
  localparam logic [3:0] OP_LD  = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b1011;
  localparam logic [3:0] OP_BR  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering fetched {instruction, pc} entries.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, wdata       write an entry (accepted when not full, or full with pop)
//   pop, rdata        rdata is the registered head; pop advances it
//   flush             empties the FIFO; wins over a push in the same cycle
//   full, empty, count occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding request at a
// time to instruction memory, buffers returned words in a small FIFO and
// presents the head to decode with a valid/stall handshake. A taken branch
// flushes the buffer and restarts fetch at the target.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   imem_req, imem_addr     request to instruction memory (held until ack)
//   imem_ack, imem_rdata    memory response for the current request
//   instr_valid, instr,     FIFO head presented to decode (NOP / pc 0 when
//   instr_pc                empty)
//   id_stall                decode not accepting; head pops on valid && !stall
//   br_taken, br_target     redirect pulse and target address
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               id_stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_nxt;
  logic [ADDR_W-1:0] drain_addr;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_after;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;

  assign instr_valid = !fifo_empty;
  assign fifo_pop    = instr_valid && !id_stall;
  // A word acked in the redirect cycle belongs to the abandoned path.
  assign fifo_push   = (state == S_FETCH) && imem_ack && !br_taken;
  assign fifo_wdata  = {imem_rdata, fetch_pc};
  assign count_after = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  assign imem_req  = (state == S_FETCH) || (state == S_DRAIN);
  // While draining, fetch_pc already holds the branch target, so the
  // in-flight address is kept separately.
  assign imem_addr = (state == S_DRAIN) ? drain_addr : fetch_pc;

  assign instr    = instr_valid ? fifo_rdata[ENTRY_W-1 -: INSTR_W] : NOP_INSTR;
  assign instr_pc = instr_valid ? fifo_rdata[ADDR_W-1:0] : '0;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (br_taken),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  // Captured only when a request is cut off by a redirect; a later redirect
  // during the drain retargets fetch_pc but not the in-flight address.
  always_ff @(posedge clk) begin
    if (state == S_FETCH && br_taken && !imem_ack) drain_addr <= fetch_pc;
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    if (br_taken) begin
      fetch_pc_nxt = br_target;
      // An unacked request cannot be retracted; wait out its ack.
      if (imem_req && !imem_ack) state_nxt = S_DRAIN;
      else                       state_nxt = S_FETCH;
    end else begin
      case (state)
        S_IDLE:  state_nxt = fifo_full ? S_FULL : S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            fetch_pc_nxt = fetch_pc + ADDR_W'(1);
            state_nxt    = (count_after < CNT_W'(FIFO_DEPTH)) ? S_FETCH : S_FULL;
          end
        end
        S_FULL:  if (fifo_pop) state_nxt = S_FETCH;
        S_DRAIN: if (imem_ack) state_nxt = S_FETCH;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized
// run. A memory model answers requests with mem[a] = a + 16'h1000 after a
// configurable number of wait cycles. The reference model is the program
// stream itself: consecutive addresses from the last reset or redirect.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        id_stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;

  int total = 0;
  int bad = 0;
  int pops = 0;

  int          mem_wait = 0;   // negative: random 0..3 per request
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [15:0] mem_addr_l = 16'h0000;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] word;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] model_pc = 16'h0000;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W     (16),
    .RESET_PC   (16'h0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .id_stall    (id_stall),
    .br_taken    (br_taken),
    .br_target   (br_target)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: latches the address on the first cycle of a request and
  // answers it after the chosen number of wait cycles.
  always @(posedge clk) begin
    #1;
    if (!imem_req) begin
      imem_ack = 1'b0;
      mem_busy = 1'b0;
    end else begin
      if (!mem_busy) begin
        mem_busy   = 1'b1;
        mem_addr_l = imem_addr;
        mem_cnt    = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
      end
      if (mem_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_addr_l + 16'h1000;
        mem_busy   = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        mem_cnt--;
      end
    end
  end

  // Scoreboard monitor: the head must always be the next word of the
  // program stream; a pop retires it. Reset/redirect restart the stream.
  always @(negedge clk) begin
    if (instr_valid) begin
      check("head_pc", instr_pc, exp_q[0].pc);
      check("head_instr", instr, exp_q[0].word);
      if (!id_stall) begin
        void'(exp_q.pop_front());
        pops++;
      end
    end else begin
      check("empty_instr", instr, NOP_INSTR);
      check("empty_pc", instr_pc, 32'h0);
    end
    if (!rst_n) begin
      exp_q.delete();
      model_pc = 16'h0000;
    end else if (br_taken) begin
      exp_q.delete();
      model_pc = br_target;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: model_pc, word: model_pc + 16'h1000});
      model_pc = model_pc + 16'h0001;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int v;
    int pops0;

    // Reset state and zero-wait streaming
    rst_n = 1'b0; mem_wait = 0;
    repeat (3) step();
    @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 16'h0000);
    check("rst_pc", instr_pc, 16'h0000);
    step(); rst_n = 1'b1;
    @(negedge clk); check("idle_req", imem_req, 1'b0);
    step(); @(negedge clk);
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step(); @(negedge clk);
      check("zw_valid", instr_valid, 1'b1);
      check("zw_instr", instr, 16'h1000 + 16'(i));
      check("zw_pc", instr_pc, 16'(i));
    end

    // Three wait cycles per word: one valid cycle in every four
    mem_wait = 3;
    repeat (8) step();
    v = 0;
    for (int i = 0; i < 40; i++) begin
      step(); @(negedge clk);
      if (instr_valid) v++;
    end
    check("wait3_valid_count", v, 10);

    // Decode stall fills the buffer and stops requests
    mem_wait = 0; id_stall = 1'b1;
    repeat (10) step();
    @(negedge clk);
    check("stall_req", imem_req, 1'b0);
    check("stall_valid", instr_valid, 1'b1);
    step(); id_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); check("nogap_valid", instr_valid, 1'b1);
      step();
    end

    // Redirect during an outstanding 2-wait request to 0x0005
    rst_n = 1'b0; step(); step(); rst_n = 1'b1; mem_wait = 2;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 16'h0005) found = 1'b1;
    end
    check("drain_found", found, 1'b1);
    br_taken = 1'b1; br_target = 16'h0040;
    step(); br_taken = 1'b0;
    @(negedge clk);
    check("drain_req", imem_req, 1'b1);
    check("drain_addr", imem_addr, 16'h0005);
    check("drain_valid", instr_valid, 1'b0);
    step(); step(); @(negedge clk);
    check("drain_next_req", imem_req, 1'b1);
    check("drain_next_addr", imem_addr, 16'h0040);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(); @(negedge clk);
      if (instr_valid) found = 1'b1;
    end
    check("drain_delivered", found, 1'b1);
    check("drain_first_pc", instr_pc, 16'h0040);
    check("drain_first_instr", instr, 16'h1040);

    // Redirect in the same cycle as the ack for 0x0007
    rst_n = 1'b0; step(); step(); rst_n = 1'b1; mem_wait = 0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 16'h0007) found = 1'b1;
    end
    check("ackbr_found", found, 1'b1);
    br_taken = 1'b1; br_target = 16'h0100;
    step(); br_taken = 1'b0;
    @(negedge clk);
    check("ackbr_req", imem_req, 1'b1);
    check("ackbr_addr", imem_addr, 16'h0100);
    check("ackbr_valid", instr_valid, 1'b0);
    step(); @(negedge clk);
    check("ackbr_first_valid", instr_valid, 1'b1);
    check("ackbr_first_pc", instr_pc, 16'h0100);

    // Reset in the middle of a request with buffered entries
    rst_n = 1'b0; step(); step(); rst_n = 1'b1; mem_wait = 3; id_stall = 1'b1;
    repeat (14) step();
    @(negedge clk);
    check("full_req", imem_req, 1'b0);
    check("full_valid", instr_valid, 1'b1);
    step(); id_stall = 1'b0;
    step(); id_stall = 1'b1;
    @(negedge clk); check("midreq_req", imem_req, 1'b1);
    step(); rst_n = 1'b0;
    step(); @(negedge clk);
    check("midrst_req", imem_req, 1'b0);
    check("midrst_valid", instr_valid, 1'b0);
    check("midrst_instr", instr, 16'h0000);
    step(); rst_n = 1'b1; id_stall = 1'b0;
    step(); @(negedge clk);
    check("restart_req", imem_req, 1'b1);
    check("restart_addr", imem_addr, 16'h0000);

    // Randomized traffic: wait states, stalls, redirects (incl. near wrap), resets
    mem_wait = -1;
    pops0 = pops;
    for (int c = 0; c < 2000; c++) begin
      step();
      id_stall  = ($urandom_range(0, 99) < 30);
      br_taken  = ($urandom_range(0, 99) < 4);
      br_target = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      rst_n     = ($urandom_range(0, 999) >= 5);
    end
    step();
    br_taken = 1'b0; rst_n = 1'b1; id_stall = 1'b0;
    repeat (10) step();
    check("random_progress", (pops - pops0) > 200, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
